// File: rtl/multi_cycle_ctr_if.sv
// Control bus between the multi-cycle controller and its datapath.
// master: the controller (consumes opCode/memReady, drives the controls).
// slave:  the datapath/memory side (drives opCode/memReady, consumes the controls).
interface multi_cycle_ctr_if;
    logic [5:0] opCode;
    logic       memReady;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       irWrite;
    logic       aluSrcA;
    logic       regWrite;
    logic       regDst;
    logic [1:0] aluOp;
    logic [1:0] aluSrcB;
    logic [1:0] pcSource;
    logic [3:0] state;
    logic       illegalOp;

    modport master (
        input  opCode, memReady,
        output pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg,
               irWrite, aluSrcA, regWrite, regDst, aluOp, aluSrcB, pcSource,
               state, illegalOp
    );

    modport slave (
        output opCode, memReady,
        input  pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg,
               irWrite, aluSrcA, regWrite, regDst, aluOp, aluSrcB, pcSource,
               state, illegalOp
    );
endinterface

// File: rtl/multi_cycle_ctr.sv
// Multi-cycle MIPS-style main controller (Moore FSM).
// Control words are decoded from the next state and registered, so every
// output comes straight from a flop; the only combinational path is the
// memReady gating of pcWrite/irWrite while in FETCH.
// Optional feature: define CTR_ILLEGAL_TRAP_EN to send illegal opcodes to a
// sticky TRAP state that raises illegalOp until reset. Without it, illegal
// opcodes behave as a NOP and illegalOp is tied low.
module multi_cycle_ctr (
    input  logic              clk,
    input  logic              resetN,
    multi_cycle_ctr_if.master bus
);

    localparam logic [3:0] FETCH     = 4'd0;
    localparam logic [3:0] DECODE    = 4'd1;
    localparam logic [3:0] MEM_ADDR  = 4'd2;
    localparam logic [3:0] MEM_READ  = 4'd3;
    localparam logic [3:0] MEM_WB    = 4'd4;
    localparam logic [3:0] MEM_WRITE = 4'd5;
    localparam logic [3:0] EXECUTE   = 4'd6;
    localparam logic [3:0] R_WB      = 4'd7;
    localparam logic [3:0] BRANCH    = 4'd8;
    localparam logic [3:0] JUMP      = 4'd9;
`ifdef CTR_ILLEGAL_TRAP_EN
    localparam logic [3:0] TRAP      = 4'd10;
`endif

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_J      = 6'b000010;

    // readyGated marks the state whose pcWrite/irWrite are qualified by memReady.
    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       irWrite;
        logic       aluSrcA;
        logic       regWrite;
        logic       regDst;
        logic [1:0] aluOp;
        logic [1:0] aluSrcB;
        logic [1:0] pcSource;
        logic       readyGated;
`ifdef CTR_ILLEGAL_TRAP_EN
        logic       illegalOp;
`endif
    } ctrlWord_t;

    logic [3:0] state_r;
    logic [3:0] nextState_s;
    ctrlWord_t  ctrl_r;
    ctrlWord_t  ctrlNext_s;
    logic       fetchQual_s;

    // Control word for a given state; unlisted controls stay 0.
    function automatic ctrlWord_t decodeCtrl(input logic [3:0] st);
        ctrlWord_t c;
        c = '0;
        case (st)
            FETCH: begin
                c.memRead    = 1'b1;
                c.aluSrcB    = 2'b01;
                c.pcWrite    = 1'b1;
                c.irWrite    = 1'b1;
                c.readyGated = 1'b1;
            end
            DECODE: begin
                c.aluSrcB = 2'b11;
            end
            MEM_ADDR: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b10;
            end
            MEM_READ: begin
                c.memRead = 1'b1;
                c.iorD    = 1'b1;
            end
            MEM_WB: begin
                c.memToReg = 1'b1;
                c.regWrite = 1'b1;
            end
            MEM_WRITE: begin
                c.memWrite = 1'b1;
                c.iorD     = 1'b1;
            end
            EXECUTE: begin
                c.aluSrcA = 1'b1;
                c.aluOp   = 2'b10;
            end
            R_WB: begin
                c.regDst   = 1'b1;
                c.regWrite = 1'b1;
            end
            BRANCH: begin
                c.aluSrcA     = 1'b1;
                c.aluOp       = 2'b01;
                c.pcWriteCond = 1'b1;
                c.pcSource    = 2'b01;
            end
            JUMP: begin
                c.pcWrite  = 1'b1;
                c.pcSource = 2'b10;
            end
`ifdef CTR_ILLEGAL_TRAP_EN
            TRAP: begin
                c.illegalOp = 1'b1;
            end
`endif
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    // Next-state selection; memReady only matters in FETCH, MEM_READ, MEM_WRITE.
    always_comb begin
        nextState_s = FETCH;
        case (state_r)
            FETCH: begin
                if (bus.memReady) begin
                    nextState_s = DECODE;
                end else begin
                    nextState_s = FETCH;
                end
            end
            DECODE: begin
                case (bus.opCode)
                    OP_LW, OP_SW: nextState_s = MEM_ADDR;
                    OP_RTYPE:     nextState_s = EXECUTE;
                    OP_BEQ:       nextState_s = BRANCH;
                    OP_J:         nextState_s = JUMP;
`ifdef CTR_ILLEGAL_TRAP_EN
                    default:      nextState_s = TRAP;
`else
                    default:      nextState_s = FETCH;
`endif
                endcase
            end
            MEM_ADDR: begin
                if (bus.opCode == OP_SW) begin
                    nextState_s = MEM_WRITE;
                end else begin
                    nextState_s = MEM_READ;
                end
            end
            MEM_READ: begin
                if (bus.memReady) begin
                    nextState_s = MEM_WB;
                end else begin
                    nextState_s = MEM_READ;
                end
            end
            MEM_WB:    nextState_s = FETCH;
            MEM_WRITE: begin
                if (bus.memReady) begin
                    nextState_s = FETCH;
                end else begin
                    nextState_s = MEM_WRITE;
                end
            end
            EXECUTE:   nextState_s = R_WB;
            R_WB:      nextState_s = FETCH;
            BRANCH:    nextState_s = FETCH;
            JUMP:      nextState_s = FETCH;
`ifdef CTR_ILLEGAL_TRAP_EN
            TRAP:      nextState_s = TRAP;
`endif
            default:   nextState_s = FETCH;
        endcase
    end

    // Pre-decode the control word of the state being entered.
    always_comb begin
        ctrlNext_s = decodeCtrl(nextState_s);
    end

    // State and control-word registers; reset overrides every transition.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_r <= FETCH;
            ctrl_r  <= decodeCtrl(FETCH);
        end else begin
            state_r <= nextState_s;
            ctrl_r  <= ctrlNext_s;
        end
    end

    // In FETCH the PC and IR only load in the cycle memory delivers the word.
    always_comb begin
        if (ctrl_r.readyGated) begin
            fetchQual_s = bus.memReady;
        end else begin
            fetchQual_s = 1'b1;
        end
    end

    assign bus.pcWrite     = ctrl_r.pcWrite & fetchQual_s;
    assign bus.irWrite     = ctrl_r.irWrite & fetchQual_s;
    assign bus.pcWriteCond = ctrl_r.pcWriteCond;
    assign bus.iorD        = ctrl_r.iorD;
    assign bus.memRead     = ctrl_r.memRead;
    assign bus.memWrite    = ctrl_r.memWrite;
    assign bus.memToReg    = ctrl_r.memToReg;
    assign bus.aluSrcA     = ctrl_r.aluSrcA;
    assign bus.regWrite    = ctrl_r.regWrite;
    assign bus.regDst      = ctrl_r.regDst;
    assign bus.aluOp       = ctrl_r.aluOp;
    assign bus.aluSrcB     = ctrl_r.aluSrcB;
    assign bus.pcSource    = ctrl_r.pcSource;
    assign bus.state       = state_r;
`ifdef CTR_ILLEGAL_TRAP_EN
    assign bus.illegalOp   = ctrl_r.illegalOp;
`else
    assign bus.illegalOp   = 1'b0;
`endif

endmodule

// File: tb/tb_multi_cycle_ctr.sv
// Testbench for multi_cycle_ctr: a planner expands each instruction into
// the per-cycle state walk implied by the controller rules (with random
// memory stalls and random memReady in states that must ignore it), and
// every cycle the observed state and controls are compared to that plan.
module tb_multi_cycle_ctr;

    logic clk = 1'b0;
    logic resetN;
    int   vectors = 0;
    int   miscompares = 0;

    multi_cycle_ctr_if bus ();

    multi_cycle_ctr dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic       mr;
        logic [5:0] op;
        logic       rstN;
    } step_t;

    step_t plan[$];

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic isLegal(input logic [5:0] op);
        return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
               (op == 6'b000100) || (op == 6'b000010);
    endfunction

    // Expected control bundle for a state, as the controller table lists it.
    function automatic logic [15:0] expCtrl(input logic [3:0] st, input logic mr);
        logic pcW, pcWC, iorD, mRd, mWr, m2r, irW, srcA, rW, rDst;
        logic [1:0] aOp, srcB, pcS;
        {pcW, pcWC, iorD, mRd, mWr, m2r, irW, srcA, rW, rDst} = 10'b0;
        {aOp, srcB, pcS} = 6'b0;
        case (st)
            4'd0: begin mRd = 1'b1; srcB = 2'b01; pcW = mr; irW = mr; end
            4'd1: srcB = 2'b11;
            4'd2: begin srcA = 1'b1; srcB = 2'b10; end
            4'd3: begin mRd = 1'b1; iorD = 1'b1; end
            4'd4: begin m2r = 1'b1; rW = 1'b1; end
            4'd5: begin mWr = 1'b1; iorD = 1'b1; end
            4'd6: begin srcA = 1'b1; aOp = 2'b10; end
            4'd7: begin rDst = 1'b1; rW = 1'b1; end
            4'd8: begin srcA = 1'b1; aOp = 2'b01; pcWC = 1'b1; pcS = 2'b01; end
            4'd9: begin pcW = 1'b1; pcS = 2'b10; end
            default: ;
        endcase
        return {pcW, pcWC, iorD, mRd, mWr, m2r, irW, srcA, rW, rDst, aOp, srcB, pcS};
    endfunction

    function automatic void push(input logic [3:0] st, input logic mr,
                                 input logic [5:0] op, input logic rstN);
        step_t s;
        s.st = st; s.mr = mr; s.op = op; s.rstN = rstN;
        plan.push_back(s);
    endfunction

    // Expand one instruction into its cycles; fStall/mStall are memReady=0 cycles.
    function automatic void planInstr(input logic [5:0] op, input int fStall, input int mStall);
        for (int i = 0; i < fStall; i++) push(4'd0, 1'b0, op, 1'b1);
        push(4'd0, 1'b1, op, 1'b1);
        push(4'd1, rnd1(), op, 1'b1);
        if (op == 6'b100011) begin
            push(4'd2, rnd1(), op, 1'b1);
            for (int i = 0; i < mStall; i++) push(4'd3, 1'b0, op, 1'b1);
            push(4'd3, 1'b1, op, 1'b1);
            push(4'd4, rnd1(), op, 1'b1);
        end else if (op == 6'b101011) begin
            push(4'd2, rnd1(), op, 1'b1);
            for (int i = 0; i < mStall; i++) push(4'd5, 1'b0, op, 1'b1);
            push(4'd5, 1'b1, op, 1'b1);
        end else if (op == 6'b000000) begin
            push(4'd6, rnd1(), op, 1'b1);
            push(4'd7, rnd1(), op, 1'b1);
        end else if (op == 6'b000100) begin
            push(4'd8, rnd1(), op, 1'b1);
        end else if (op == 6'b000010) begin
            push(4'd9, rnd1(), op, 1'b1);
        end else begin
`ifdef CTR_ILLEGAL_TRAP_EN
            for (int i = 0; i < 20; i++) push(4'd10, rnd1(), op, 1'b1);
            push(4'd10, rnd1(), op, 1'b0);
`endif
        end
    endfunction

    task automatic checkCycle(input step_t s);
        logic [15:0] obs;
        logic [15:0] exp;
        logic        expIll;
        @(negedge clk);
        bus.memReady = s.mr;
        bus.opCode   = s.op;
        resetN       = s.rstN;
        #1;
        obs = {bus.pcWrite, bus.pcWriteCond, bus.iorD, bus.memRead, bus.memWrite,
               bus.memToReg, bus.irWrite, bus.aluSrcA, bus.regWrite, bus.regDst,
               bus.aluOp, bus.aluSrcB, bus.pcSource};
        exp = expCtrl(s.st, s.mr);
`ifdef CTR_ILLEGAL_TRAP_EN
        expIll = (s.st == 4'd10);
`else
        expIll = 1'b0;
`endif
        vectors++;
        assert (bus.state === s.st) else begin
            miscompares++;
            $error("FAIL state: observed %0d expected %0d (t=%0t)", bus.state, s.st, $time);
        end
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL ctrl(state %0d): observed %b expected %b (t=%0t)", s.st, obs, exp, $time);
        end
        vectors++;
        assert (bus.illegalOp === expIll) else begin
            miscompares++;
            $error("FAIL illegalOp: observed %b expected %b (t=%0t)", bus.illegalOp, expIll, $time);
        end
    endtask

    task automatic runPlan();
        step_t s;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            checkCycle(s);
        end
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] legalOps [5];
        legalOps[0] = 6'b100011; legalOps[1] = 6'b101011; legalOps[2] = 6'b000000;
        legalOps[3] = 6'b000100; legalOps[4] = 6'b000010;

        resetN       = 1'b0;
        bus.memReady = 1'b1;
        bus.opCode   = 6'b000000;
        @(posedge clk);

        // Reset held low with memReady=1: FETCH values, then an R-type.
        push(4'd0, 1'b1, 6'b000000, 1'b0);
        push(4'd0, 1'b1, 6'b000000, 1'b0);
        planInstr(6'b000000, 0, 0);
        // lw with two MEM_READ stalls; sw, beq, j back to back.
        planInstr(6'b100011, 0, 2);
        planInstr(6'b101011, 0, 0);
        planInstr(6'b000100, 0, 0);
        planInstr(6'b000010, 0, 0);
        // Three FETCH stalls before an R-type.
        planInstr(6'b000000, 3, 0);
        // Illegal opcode (trap held then reset, or NOP).
        planInstr(6'b010101, 0, 0);
        runPlan();

        // Reset asserted while stalled in MEM_WRITE.
        push(4'd0, 1'b1, 6'b101011, 1'b1);
        push(4'd1, 1'b1, 6'b101011, 1'b1);
        push(4'd2, 1'b1, 6'b101011, 1'b1);
        push(4'd5, 1'b0, 6'b101011, 1'b0);
        push(4'd0, 1'b0, 6'b101011, 1'b1);
        // Reset asserted while stalled in MEM_READ.
        push(4'd0, 1'b1, 6'b100011, 1'b1);
        push(4'd1, 1'b0, 6'b100011, 1'b1);
        push(4'd2, 1'b0, 6'b100011, 1'b1);
        push(4'd3, 1'b0, 6'b100011, 1'b0);
        push(4'd0, 1'b0, 6'b100011, 1'b1);
        runPlan();

        // Randomized instruction stream with random stalls.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do begin
                    op = 6'($urandom_range(0, 63));
                end while (isLegal(op));
            end else begin
                op = legalOps[$urandom_range(0, 4)];
            end
            planInstr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            runPlan();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctr.md
MULTI_CYCLE_CTR -- requirements
Module: multi_cycle_ctr

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port resetN, input, 1 bit: synchronous, active-low reset.
REQ-003 The block SHALL have the port opCode, input, 6 bits: instruction[31:26] from the datapath IR, valid from DECODE until the instruction returns to FETCH.
REQ-004 The block SHALL have the port memReady, input, 1 bit: memory completes the current access in this cycle.
REQ-005 The block SHALL have the ports pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg, irWrite, aluSrcA, regWrite and regDst, each an output of 1 bit: the datapath controls.
REQ-006 The block SHALL have the port aluOp, output, 2 bits: 00 = add, 01 = subtract, 10 = funct-decoded.
REQ-007 The block SHALL have the port aluSrcB, output, 2 bits: 00 = regB, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
REQ-008 The block SHALL have the port pcSource, output, 2 bits: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-009 The block SHALL have the port state, output, 4 bits: the current state encoding, for debug.
REQ-010 The block SHALL have the port illegalOp, output, 1 bit: the trap flag (see Configuration).

Function
REQ-011 The block SHALL be a Moore FSM, except that pcWrite and irWrite in FETCH are gated by memReady; every output not listed for a state SHALL be 0.
REQ-012 State encodings SHALL be: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, TRAP=10.
REQ-013 FETCH SHALL drive memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00, and pcWrite=irWrite=memReady.
REQ-014 FETCH SHALL go to DECODE when memReady=1 and SHALL otherwise stay in FETCH.
REQ-015 DECODE SHALL drive aluSrcA=0, aluSrcB=11, aluOp=00.
REQ-016 DECODE SHALL go to MEM_ADDR for opCode 100011 (lw) or 101011 (sw), EXECUTE for 000000, BRANCH for 000100, JUMP for 000010, and SHALL treat any other opCode as illegal (REQ-030).
REQ-017 MEM_ADDR SHALL drive aluSrcA=1, aluSrcB=10, aluOp=00, and SHALL go to MEM_READ for lw and MEM_WRITE for sw.
REQ-018 MEM_READ SHALL drive memRead=1, iorD=1, and SHALL go to MEM_WB on memReady=1, else stay.
REQ-019 MEM_WB SHALL drive regDst=0, memToReg=1, regWrite=1, and SHALL go to FETCH.
REQ-020 MEM_WRITE SHALL drive memWrite=1, iorD=1, and SHALL go to FETCH on memReady=1, else stay.
REQ-021 EXECUTE SHALL drive aluSrcA=1, aluSrcB=00, aluOp=10, and SHALL go to R_WB.
REQ-022 R_WB SHALL drive regDst=1, regWrite=1, memToReg=0, and SHALL go to FETCH.
REQ-023 BRANCH SHALL drive aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01, and SHALL go to FETCH.
REQ-024 JUMP SHALL drive pcWrite=1, pcSource=10, and SHALL go to FETCH.
REQ-025 Instruction latency with memReady held at 1 SHALL be: R-type 4 cycles, lw 5, sw 4, beq 3, j 3; each extra cycle with memReady=0 in FETCH, MEM_READ or MEM_WRITE SHALL add exactly one cycle.
REQ-026 memReady SHALL be ignored in every state other than FETCH, MEM_READ and MEM_WRITE.
REQ-027 Unused encodings 11-15 SHALL go to FETCH on the next edge, with all outputs 0.

Reset
REQ-028 While resetN=0 at a rising edge, the FSM SHALL enter FETCH; illegalOp SHALL clear to 0; outputs SHALL then take their FETCH values.
REQ-029 Reset SHALL take priority over every transition, including mid-MEM_READ, mid-MEM_WRITE and TRAP; no memWrite pulse SHALL occur in the cycle after reset is asserted.

Configuration
REQ-030 With CTR_ILLEGAL_TRAP_EN defined, an illegal opCode in DECODE SHALL go to TRAP, where illegalOp=1 and all other outputs are 0, and TRAP SHALL be held until reset; with the macro undefined, an illegal opCode SHALL go to FETCH (NOP), TRAP SHALL be unreachable, and illegalOp SHALL be tied to 0.

Verification
REQ-031 Scenario: reset low for 2 cycles, then high, with memReady=1 and opCode=000000 -> state sequence 0,1,6,7,0; regWrite=1 and regDst=1 only in state 7.
REQ-032 Scenario: opCode=100011 with memReady low for 2 cycles while in MEM_READ -> states 0,1,2,3,3,3,4,0 (7 cycles); memToReg=1 in state 4.
REQ-033 Scenario: opCode=101011, then 000100, then 000010, with memReady=1 -> states 0,1,2,5,0 / 0,1,8,0 / 0,1,9,0; pcWriteCond=1 only in state 8; pcSource=10 in state 9.
REQ-034 Scenario: opCode=010101 -> with the macro: state 10 and illegalOp=1 held for 20 cycles until reset; without the macro: states 0,1,0 and illegalOp=0.
REQ-035 Scenario: resetN driven low for 1 cycle while in state 5 with memReady=0 -> next state 0; memWrite=0 from that edge onward.
REQ-036 Scenario: memReady=0 for 3 cycles in FETCH -> pcWrite=irWrite=0 for those 3 cycles, then both =1 for exactly 1 cycle.
